ureg_sched: RTL and testbench

UREG_SCHED -- requirements
Module: ureg_sched

---
 rtl/ureg_sched.sv | 188 ++++++++++++++++++
 tb/tb_ureg_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ureg_sched.sv
// ureg_sched: user-register-programmed timed event scheduler.
// Commands written by the core are queued with an absolute timestamp and
// released on a valid/ready event port when the free-running timer reaches them.
module ureg_sched #(
    parameter int DEPTH  = 16,
    parameter int LATE_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ureg_we,
    input  logic [7:0]  i_ureg_waddr,
    input  logic [31:0] i_ureg_wdata,
    input  logic [2:0]  i_ureg_raddr,
    output logic [31:0] o_ureg_rdata,
    output logic        o_hlt,
    output logic [31:0] o_jmp_offset,
    output logic        o_evt_valid,
    output logic [5:0]  o_evt_chan,
    output logic [31:0] o_evt_data,
    input  logic        i_evt_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [5:0]  chan;
        logic [31:0] data;
        logic [31:0] ts;
    } cmd_t;

    cmd_t              r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [31:0]       r_t;
    logic [31:0]       r_s;
    logic [31:0]       r_d;
    logic              r_run;
    logic              r_ovf;
    logic [LATE_W-1:0] r_late;
    logic [31:0]       r_jmp;
    logic              r_hlt;
    logic              r_evt_valid;
    logic [5:0]        r_evt_chan;
    logic [31:0]       r_evt_data;

    logic              w_wr_d;
    logic              w_wr_jmp;
    logic              w_wr_ctrl;
    logic              w_wr_cmd;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_late;
    logic [31:0]       w_diff;
    logic [31:0]       w_ts;
    logic [CW-1:0]     w_count_next;
    cmd_t              w_head;

    // Address decode and the dispatch decision for this cycle.
    always_comb begin
        w_wr_d    = i_ureg_we && (i_ureg_waddr == 8'h00);
        w_wr_jmp  = i_ureg_we && (i_ureg_waddr == 8'h01);
        w_wr_ctrl = i_ureg_we && (i_ureg_waddr == 8'h02);
        w_wr_cmd  = i_ureg_we && (i_ureg_waddr[7:6] == 2'b01);
        w_full    = (r_count == CW'(DEPTH));
        w_push    = w_wr_cmd && !w_full;
        w_ts      = r_s + r_d;
        w_head    = r_mem[r_rptr];
        // Wrap-safe "T has reached ts": the modular distance is non-negative.
        w_diff    = r_t - w_head.ts;
        w_pop     = r_run && (r_count != '0) && !w_diff[31]
                    && (!r_evt_valid || i_evt_ready);
        w_late    = w_pop && (r_t != w_head.ts);
    end

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_count_next = r_count - CW'(1);
    end

    // Control registers: timer, schedule pointer S, delay D, run, flags.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_rst) begin
            r_t    <= '0;
            r_s    <= '0;
            r_d    <= '0;
            r_run  <= 1'b0;
            r_ovf  <= 1'b0;
            r_late <= '0;
            r_jmp  <= '0;
        end else begin
            if (w_wr_ctrl && i_ureg_wdata[1]) begin
                r_t <= '0;
                r_s <= '0;
            end else begin
                if (r_run)
                    r_t <= r_t + 32'd1;
                if (w_push)
                    r_s <= w_ts;
            end
            if (w_wr_ctrl)
                r_run <= i_ureg_wdata[0];
            if (w_wr_d)
                r_d <= i_ureg_wdata;
            if (w_wr_jmp)
                r_jmp <= i_ureg_wdata;
            // A flag clear wins over a same-cycle late dispatch.
            if (w_wr_ctrl && i_ureg_wdata[2]) begin
                r_ovf  <= 1'b0;
                r_late <= '0;
            end else begin
                if (w_wr_cmd && w_full)
                    r_ovf <= 1'b1;
                if (w_late && (r_late != '1))
                    r_late <= r_late + LATE_W'(1);
            end
        end
    end

    // Command storage; contents are only meaningful between the pointers.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers define validity.
        if (!i_rst && w_push)
            r_mem[r_wptr] <= '{chan: i_ureg_waddr[5:0], data: i_ureg_wdata, ts: w_ts};
    end

    // FIFO pointers, occupancy and the registered stall request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_hlt   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
            // Raised one entry early so a write already in flight still fits.
            r_hlt   <= (w_count_next >= CW'(DEPTH - 1));
        end
    end

    // Event output register with valid/ready hold semantics.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_data  <= '0;
        end else if (w_pop) begin
            r_evt_valid <= 1'b1;
            r_evt_chan  <= w_head.chan;
            r_evt_data  <= w_head.data;
        end else if (i_evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    // Combinational register readback.
    always_comb begin
        o_ureg_rdata = '0;
        case (i_ureg_raddr)
            3'd0:    o_ureg_rdata = r_t;
            3'd1:    o_ureg_rdata = r_s;
            3'd2:    o_ureg_rdata = {23'b0, r_ovf, 8'(r_count)};
            3'd3:    o_ureg_rdata = r_d;
            3'd4:    o_ureg_rdata = 32'(r_late);
            3'd5:    o_ureg_rdata = r_jmp;
            default: o_ureg_rdata = '0;
        endcase
    end

    assign o_hlt        = r_hlt;
    assign o_jmp_offset = r_jmp;
    assign o_evt_valid  = r_evt_valid;
    assign o_evt_chan   = r_evt_chan;
    assign o_evt_data   = r_evt_data;

endmodule

// File: tb/tb_ureg_sched.sv
// tb_ureg_sched: directed scenarios plus randomized traffic, all compared
// every cycle against a queue-based model of the scheduler.
module tb_ureg_sched;

    localparam int DEPTH    = 16;
    localparam int LATE_MAX = 65535;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ureg_we = 1'b0;
    logic [7:0]  i_ureg_waddr = '0;
    logic [31:0] i_ureg_wdata = '0;
    logic [2:0]  i_ureg_raddr = '0;
    logic        i_evt_ready = 1'b0;
    logic [31:0] o_ureg_rdata;
    logic        o_hlt;
    logic [31:0] o_jmp_offset;
    logic        o_evt_valid;
    logic [5:0]  o_evt_chan;
    logic [31:0] o_evt_data;

    ureg_sched #(.DEPTH(DEPTH), .LATE_W(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ureg_we    (i_ureg_we),
        .i_ureg_waddr (i_ureg_waddr),
        .i_ureg_wdata (i_ureg_wdata),
        .i_ureg_raddr (i_ureg_raddr),
        .o_ureg_rdata (o_ureg_rdata),
        .o_hlt        (o_hlt),
        .o_jmp_offset (o_jmp_offset),
        .o_evt_valid  (o_evt_valid),
        .o_evt_chan   (o_evt_chan),
        .o_evt_data   (o_evt_data),
        .i_evt_ready  (i_evt_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit [5:0]  chan;
        bit [31:0] data;
        bit [31:0] ts;
    } ev_t;

    ev_t         q[$];
    bit          model_ok = 0;
    bit [31:0]   m_t, m_s, m_d, m_jmp, m_data;
    bit [5:0]    m_chan;
    bit          m_run, m_ovf, m_valid, m_hlt;
    int unsigned m_late;

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0:    return m_t;
            3'd1:    return m_s;
            3'd2:    return {23'b0, m_ovf, 8'(q.size())};
            3'd3:    return m_d;
            3'd4:    return m_late;
            3'd5:    return m_jmp;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge i_clk) begin : model_blk
        bit   disp, late_evt, full, old_run, is_ctrl;
        ev_t  h;
        if (i_rst) begin
            m_t = 0; m_s = 0; m_d = 0; m_jmp = 0; m_data = 0; m_chan = 0;
            m_run = 0; m_ovf = 0; m_valid = 0; m_late = 0;
            q.delete();
            model_ok = 1;
        end else begin
            full     = (q.size() == DEPTH);
            disp     = m_run && q.size() > 0 && ((m_t - q[0].ts) < 32'h8000_0000)
                       && (!m_valid || i_evt_ready);
            late_evt = disp && (m_t != q[0].ts);
            if (disp) begin
                h = q.pop_front();
                m_valid = 1; m_chan = h.chan; m_data = h.data;
            end else if (i_evt_ready) begin
                m_valid = 0;
            end
            old_run = m_run;
            is_ctrl = i_ureg_we && i_ureg_waddr == 8'h02;
            if (is_ctrl && i_ureg_wdata[1]) begin
                m_t = 0; m_s = 0;
            end else if (old_run) begin
                m_t = m_t + 1;
            end
            if (is_ctrl) m_run = i_ureg_wdata[0];
            if (i_ureg_we && i_ureg_waddr == 8'h00) m_d = i_ureg_wdata;
            if (i_ureg_we && i_ureg_waddr == 8'h01) m_jmp = i_ureg_wdata;
            if (i_ureg_we && i_ureg_waddr >= 8'h40 && i_ureg_waddr <= 8'h7F) begin
                if (full) m_ovf = 1;
                else begin
                    q.push_back('{i_ureg_waddr[5:0], i_ureg_wdata, m_s + m_d});
                    m_s = m_s + m_d;
                end
            end
            if (is_ctrl && i_ureg_wdata[2]) begin
                m_ovf = 0; m_late = 0;
            end else if (late_evt && m_late != LATE_MAX) begin
                m_late++;
            end
        end
        m_hlt = (q.size() >= DEPTH - 1);
    end

    // Compare process: outputs are settled on the falling edge.
    always @(negedge i_clk) begin
        if (model_ok) begin
            check("evt_valid", {31'b0, o_evt_valid}, {31'b0, m_valid});
            if (m_valid) begin
                check("evt_chan", {26'b0, o_evt_chan}, {26'b0, m_chan});
                check("evt_data", o_evt_data, m_data);
            end
            check("hlt", {31'b0, o_hlt}, {31'b0, m_hlt});
            check("jmp_offset", o_jmp_offset, m_jmp);
            check("rdata", o_ureg_rdata, model_rd(i_ureg_raddr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic we, input logic [7:0] wa,
                        input logic [31:0] wd, input logic rdy, input logic [2:0] ra);
        @(negedge i_clk);
        #1;
        i_rst = rst; i_ureg_we = we; i_ureg_waddr = wa; i_ureg_wdata = wd;
        i_evt_ready = rdy; i_ureg_raddr = ra;
        #1;
    endtask

    task automatic idle(input logic rdy, input logic [2:0] ra);
        step(1'b0, 1'b0, 8'h00, 32'h0, rdy, ra);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd0);
        idle(1'b0, 3'd0);
    endtask

    initial begin : stim
        int waited;
        do_reset();
        check("reset_valid", {31'b0, o_evt_valid}, 32'd0);
        check("reset_hlt", {31'b0, o_hlt}, 32'd0);
        idle(1'b0, 3'd2);
        check("reset_status", o_ureg_rdata, 32'd0);

        // D=10, one command, run+clear: event after T==10, seen with T=11.
        step(1'b0, 1'b1, 8'h00, 32'd10, 1'b1, 3'd0);
        step(1'b0, 1'b1, 8'h43, 32'hA5, 1'b1, 3'd0);
        step(1'b0, 1'b1, 8'h02, 32'h3,  1'b1, 3'd0);
        waited = 0;
        while (!o_evt_valid && waited < 30) begin
            idle(1'b1, 3'd0);
            waited++;
        end
        check("first_evt_seen", {31'b0, o_evt_valid}, 32'd1);
        check("first_evt_chan", {26'b0, o_evt_chan}, 32'd3);
        check("first_evt_data", o_evt_data, 32'hA5);
        check("first_evt_T", o_ureg_rdata, 32'd11);

        // Fill with run=0: stall after 15 writes, 17th dropped.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            step(1'b0, 1'b1, 8'h40 + 8'(k), 32'(k), 1'b0, 3'd2);
            check("hlt_during_fill", {31'b0, o_hlt}, (k - 1 >= 15) ? 32'd1 : 32'd0);
        end
        idle(1'b0, 3'd2);
        check("overflow_status", o_ureg_rdata, 32'h110);

        // Run with ready low: one event held; then reset clears everything.
        step(1'b0, 1'b1, 8'h02, 32'h1, 1'b0, 3'd2);
        idle(1'b0, 3'd2);
        idle(1'b0, 3'd2);
        idle(1'b0, 3'd2);
        check("held_valid", {31'b0, o_evt_valid}, 32'd1);
        check("held_chan", {26'b0, o_evt_chan}, 32'd1);
        step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd2);
        idle(1'b1, 3'd2);
        check("rst_valid", {31'b0, o_evt_valid}, 32'd0);
        check("rst_status", o_ureg_rdata, 32'd0);
        for (int k = 0; k < 8; k++) begin
            idle(1'b1, 3'd2);
            check("no_evt_after_rst", {31'b0, o_evt_valid}, 32'd0);
        end

        // Wrap-safe due test: ts=0xFFFFFFF8 is in the past, ts=8 waits for T==8.
        do_reset();
        step(1'b0, 1'b1, 8'h00, 32'hFFFF_FFF8, 1'b1, 3'd0);
        step(1'b0, 1'b1, 8'h41, 32'd111, 1'b1, 3'd0);
        step(1'b0, 1'b1, 8'h00, 32'd16, 1'b1, 3'd0);
        step(1'b0, 1'b1, 8'h42, 32'd222, 1'b1, 3'd0);
        step(1'b0, 1'b1, 8'h02, 32'h1, 1'b1, 3'd0);
        waited = 0;
        while (!(o_evt_valid && o_evt_chan == 6'd2) && waited < 40) begin
            idle(1'b1, 3'd0);
            waited++;
        end
        check("wrap_evt_data", o_evt_data, 32'd222);
        check("wrap_evt_T", o_ureg_rdata, 32'd9);
        idle(1'b1, 3'd4);
        check("wrap_late_cnt", o_ureg_rdata, 32'd1);
        idle(1'b1, 3'd1);
        check("wrap_S", o_ureg_rdata, 32'd8);

        // Randomized traffic, checked every cycle by the compare process.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r, sel;
            logic [7:0]  wa;
            logic [31:0] wd;
            r   = $urandom_range(0, 99);
            sel = $urandom_range(0, 99);
            wa  = 8'h00;
            wd  = $urandom;
            if (sel < 55) begin
                wa = 8'h40 | 8'($urandom_range(0, 63));
            end else if (sel < 70) begin
                wa = 8'h00;
                wd = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
            end else if (sel < 78) begin
                wa = 8'h01;
            end else if (sel < 90) begin
                wa = 8'h02;
                wd = {29'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 6) != 0)};
            end else begin
                wa = 8'($urandom);
            end
            step((r == 0), (r < 60), wa, wd, ($urandom_range(0, 99) < 70),
                 3'($urandom_range(0, 7)));
        end
        idle(1'b1, 3'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
